seg_display_arbiter: RTL and testbench
======================================

# seg_display_arbiter

Time-shares the single 7-segment output (`uo_out[7:1]`) among up to `N_SRC` digit sources, such as the counter banks, using round-robin scheduling. Each granted source is shown for a programmable number of divided-clock ticks, with one blanking tick between sources to prevent ghosting. The BCD-to-segment decode is built in. The block sits between the counters and the top-level output mux, clocked by the system clock and paced by the divider's one-cycle `tick` strobe.

## Interface
Parameters:
- `N_SRC`, 4: number of digit sources (2..8).
- `DWELL_W`, 8: width of the dwell count.
- `IDX_W`, `$clog2(N_SRC)`: width of the source index.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `tick`  in  1  time-base strobe, one `clk` cycle wide.
- `req`  in  `N_SRC`  bit i set means source i wants the display.
- `digit_in`  in  `4*N_SRC`  packed BCD nibbles; source i is `[4i+3:4i]`.
- `dwell`  in  `DWELL_W`  ticks per grant; sampled at grant load; 0 is treated as 1.
- `lock`  in  1  freezes the current grant and dwell countdown.
- `grant`  out  `N_SRC`  one-hot grant; all zero when none.
- `src_idx`  out  `IDX_W`  index of the granted source; 0 when none.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active high.
- `seg_valid`  out  1  high while in SHOW.

## Operation
- States: IDLE, SHOW, BLANK. All outputs are registered.
- Reset (`rst_n`=0 at an edge):
  - state = IDLE.
  - `grant`=0, `src_idx`=0, `seg`=0, `seg_valid`=0.
  - Round-robin pointer `ptr`=0; dwell counter = 0.
- Arbitration: pick the first requesting source, searching from `ptr` upward and wrapping modulo `N_SRC`. On a grant to i, set `ptr` to (i+1) mod `N_SRC`.
- IDLE:
  - If any `req` bit is set, arbitrate every cycle (no `tick` needed), then go to SHOW.
  - Load the dwell counter with max(`dwell`,1).
- SHOW:
  - `seg` = decode(`digit_in` of the granted source), updated every cycle.
  - `seg_valid`=1.
  - On `tick` with `lock`=0: decrement the counter.
  - When the counter goes 1 to 0 (expiry):
    - If another source requests, go to BLANK.
    - Else, if the current source still requests, reload the counter and stay in SHOW; `ptr` is unchanged.
    - Else go to BLANK.
  - Granted `req` bit drops: go to BLANK on the next edge, whatever the state of `lock` or `tick`.
  - `lock`=1: the counter holds and expiry is suppressed; a drop of the granted request still wins.
- BLANK:
  - `grant`=0, `seg`=0, `seg_valid`=0, `src_idx`=0.
  - On the next `tick`: if any `req`, arbitrate and go to SHOW; otherwise go to IDLE.
- Decode table:
  - 0=`0111111`, 1=`0000110`, 2=`1011011`, 3=`1001111`, 4=`1100110`
  - 5=`1101101`, 6=`1111101`, 7=`0000111`, 8=`1111111`, 9=`1101111`
  - 10..15 show a dash, `1000000`.
- Simultaneous events:
  - Expiry and request drop in the same cycle: go to BLANK.
  - `tick` in the same cycle as entering BLANK does not count; BLANK lasts until the following `tick`.
  - `rst_n`=0 overrides everything, including mid-SHOW and mid-BLANK.

## Timing
- IDLE with `req` rising at edge t: `grant`, `seg` and `seg_valid` are valid after edge t+1.
- Digit change while in SHOW: `seg` follows one cycle later.
- Grant duration = `dwell` ticks. The first decrement happens on the first `tick` after the grant edge.
- BLANK lasts from the exit edge until the edge that samples the next `tick`, i.e. at most one tick period plus one cycle.
- Request drop: `grant` clears one cycle after the dropped `req` is sampled.
- `grant` is always one-hot or zero, and `src_idx` always matches `grant`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req`=4'b1111. Outputs stay 0 throughout. One cycle after release, `grant`=0001, `seg`=decode(`digit_in[3:0]`).
- Round robin: `req`=1111, `dwell`=2, digits {3,2,1,0}. The grant sequence is 0001, BLANK, 0010, BLANK, 0100, BLANK, 1000, BLANK, 0001. Each SHOW spans exactly 2 ticks; `seg` during source 2 is `0000110`.
- Sole requester: `req`=0100, `dwell`=3, run 10 ticks. `grant` stays 0100 with no BLANK. Raising `req` to 0101 switches to source 0 via BLANK at the next expiry.
- Lock and drop: grant source 1, set `lock`=1, run 20 ticks; `grant` stays 0010. Drop `req[1]`; `grant`=0 on the next cycle. With no other request, the next `tick` returns to IDLE.
- Edge values: `dwell`=0 behaves as 1. Digit 12 shows `seg`=`1000000`. Asserting `rst_n`=0 mid-SHOW clears `grant` and `ptr`, so the next grant goes to source 0.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of one 7-segment display among N_SRC BCD sources,
// with a programmable dwell per grant and one blanking tick between sources.
module seg_display_arbiter #(
  parameter int N_SRC   = 4,
  parameter int DWELL_W = 8,
  parameter int IDX_W   = $clog2(N_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [N_SRC-1:0]     req,
  input  logic [4*N_SRC-1:0]   digit_in,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 lock,
  output logic [N_SRC-1:0]     grant,
  output logic [IDX_W-1:0]     src_idx,
  output logic [6:0]           seg,
  output logic                 seg_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [DWELL_W-1:0] cnt;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [DWELL_W-1:0] dwell_load;
  logic [3:0]         cur_digit;
  logic [3:0]         pick_digit;
  logic               any_req;
  logic               cur_req;
  logic               other_req;
  logic               expire;
  logic               do_load;
  logic               leave_show;
  logic               to_idle;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // Search downward so the last hit is the first requester at or after ptr.
  always_comb begin
    cand     = '0;
    pick_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_SRC);
      if (req[cand]) begin
        pick_idx = cand;
      end else begin
        pick_idx = pick_idx;
      end
    end
  end

  assign next_ptr   = (pick_idx == IDX_W'(N_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign cur_digit  = 4'(digit_in >> {src_idx, 2'b00});
  assign pick_digit = 4'(digit_in >> {pick_idx, 2'b00});
  assign any_req    = |req;
  assign cur_req    = |(req & grant);
  assign other_req  = |(req & ~grant);
  assign expire     = tick && !lock && (cnt <= DWELL_W'(1));

  // A dropped grant request wins over lock; expiry only yields to a rival.
  assign do_load    = any_req && ((state == ST_IDLE) || (state == ST_BLANK && tick));
  assign leave_show = (state == ST_SHOW) && (!cur_req || (expire && other_req));
  assign to_idle    = (state == ST_BLANK) && tick && !any_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      src_idx   <= '0;
      seg       <= 7'b0000000;
      seg_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else if (do_load) begin
      state     <= ST_SHOW;
      grant     <= N_SRC'(1) << pick_idx;
      src_idx   <= pick_idx;
      seg       <= decode(pick_digit);
      seg_valid <= 1'b1;
      ptr       <= next_ptr;
      cnt       <= dwell_load;
    end else if (leave_show) begin
      state     <= ST_BLANK;
      grant     <= '0;
      src_idx   <= '0;
      seg       <= 7'b0000000;
      seg_valid <= 1'b0;
      cnt       <= '0;
    end else if (to_idle) begin
      state <= ST_IDLE;
    end else if (state == ST_SHOW) begin
      seg <= decode(cur_digit);
      if (tick && !lock) begin
        cnt <= expire ? dwell_load : cnt - DWELL_W'(1);
      end
    end else if (state != ST_IDLE && state != ST_BLANK) begin
      state     <= ST_IDLE;
      grant     <= '0;
      src_idx   <= '0;
      seg       <= 7'b0000000;
      seg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed plus randomized bench for seg_display_arbiter, checked every cycle
// against a behavioural model of the round-robin display schedule.
module tb_seg_display_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic [N-1:0] req;
  logic [15:0]  digit_in;
  logic [7:0]   dwell;
  logic         lock;
  logic [N-1:0] grant;
  logic [1:0]   src_idx;
  logic [6:0]   seg;
  logic         seg_valid;

  int errors = 0;
  int checks = 0;

  seg_display_arbiter #(.N_SRC(N), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .digit_in(digit_in),
    .dwell(dwell), .lock(lock), .grant(grant), .src_idx(src_idx),
    .seg(seg), .seg_valid(seg_valid)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                              7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  // Model: who is on screen, whether we are waiting out a blank, ticks left.
  bit         m_show = 0;
  bit         m_blank = 0;
  int         m_cur = 0;
  int         m_rem = 0;
  int         m_ptr = 0;
  logic [6:0] m_seg = 7'b0;

  bit         rec_on = 0;
  int         seq_q[$];
  int         last_g = -1;

  function automatic int digit_of(int i);
    logic [15:0] d;
    d = digit_in >> (4 * i);
    return int'(d[3:0]);
  endfunction

  task automatic model_pick();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) begin
        m_cur   = (m_ptr + k) % N;
        m_ptr   = (m_cur + 1) % N;
        m_rem   = (dwell == 0) ? 1 : int'(dwell);
        m_show  = 1;
        m_blank = 0;
        m_seg   = dec_tab[digit_of(m_cur)];
        return;
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_show = 0; m_blank = 0; m_cur = 0; m_rem = 0; m_ptr = 0; m_seg = 7'b0;
    end else if (m_show) begin
      if (!req[m_cur]) begin
        m_show = 0; m_blank = 1;
      end else begin
        if (tick && !lock) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            if ((req & ~(4'b0001 << m_cur)) != 0) begin
              m_show = 0; m_blank = 1;
            end else begin
              m_rem = (dwell == 0) ? 1 : int'(dwell);
            end
          end
        end
        if (m_show) m_seg = dec_tab[digit_of(m_cur)];
      end
    end else if (m_blank) begin
      if (tick) begin
        m_blank = 0;
        if (req != 0) model_pick();
      end
    end else if (req != 0) begin
      model_pick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant",     32'(grant),     m_show ? 32'(4'b0001 << m_cur) : 32'd0);
    chk("src_idx",   32'(src_idx),   m_show ? 32'(m_cur) : 32'd0);
    chk("seg_valid", 32'(seg_valid), 32'(m_show));
    chk("seg",       32'(seg),       m_show ? 32'(m_seg) : 32'd0);
    if (rec_on && int'(grant) != last_g) begin
      seq_q.push_back(int'(grant));
      last_g = int'(grant);
    end
  endtask

  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      tick = (k % per == per - 1);
      step();
    end
    tick = 1'b0;
  endtask

  int bad;
  bit seen;
  int exp_seq[9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};

  initial begin
    rst_n = 1'b0; tick = 1'b0; req = 4'b1111; digit_in = 16'h0123;
    dwell = 8'd2; lock = 1'b0;

    // Reset held with all sources requesting
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_grant", 32'(grant), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_reset_grant", 32'(grant), 32'd1);
    chk("post_reset_seg", 32'(seg), 32'(7'b1001111));

    // Round robin, dwell 2, tick every 4 cycles
    rec_on = 1; seq_q.push_back(int'(grant)); last_g = int'(grant);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      tick = (k % 4 == 3);
      step();
      if (grant === 4'b0100 && seg !== 7'b0000110) bad++;
    end
    tick = 1'b0; rec_on = 0;
    chk("rr_seq_len_ok", 32'(seq_q.size() >= 9), 32'd1);
    for (int k = 0; k < 9 && k < seq_q.size(); k++)
      chk("rr_seq", 32'(seq_q[k]), 32'(exp_seq[k]));
    chk("rr_src2_seg", 32'(bad), 32'd0);

    // Sole requester
    req = 4'b0100; dwell = 8'd3;
    run(20, 4);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick = (k % 4 == 3);
      step();
      if (grant !== 4'b0100) bad++;
    end
    tick = 1'b0;
    chk("sole_hold", 32'(bad), 32'd0);
    req = 4'b0101; seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick = (k % 4 == 3);
      step();
      if (grant === 4'b0001) seen = 1;
    end
    tick = 1'b0;
    chk("sole_switch_to_0", 32'(seen), 32'd1);

    // Lock and drop
    req = 4'b0010; seen = 0;
    for (int k = 0; k < 24 && !seen; k++) begin
      tick = (k % 4 == 3);
      step();
      if (grant === 4'b0010) seen = 1;
    end
    tick = 1'b0;
    chk("lock_get_src1", 32'(seen), 32'd1);
    lock = 1'b1; bad = 0;
    for (int k = 0; k < 80; k++) begin
      tick = (k % 4 == 3);
      step();
      if (grant !== 4'b0010) bad++;
    end
    tick = 1'b0;
    chk("lock_hold", 32'(bad), 32'd0);
    req = 4'b0000;
    step();
    chk("drop_clears", 32'(grant), 32'd0);
    lock = 1'b0;
    run(4, 4);
    req = 4'b0001;
    step();
    chk("idle_immediate_grant", 32'(grant), 32'd1);

    // Dwell 0 and dash digit
    dwell = 8'd0; digit_in = 16'h012C;
    run(12, 3);
    chk("dash_seg", 32'(seg), 32'(7'b1000000));
    req = 4'b1111;
    run(3, 4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("reset_mid_show_grant", 32'(grant), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) digit_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
